instr_seq: RTL and testbench

- Parametrised instruction sequencer for the 6502 core; the next generation of the instruction-control block.
- Holds the instruction register (IR) and the per-instruction cycle counter.
- Adds reset, NMI and IRQ sequencing: at instruction boundaries it injects a BRK opcode and reports which vector the microcode must use.
- Sits between the data bus and the decode/microcode ROM, which drives inc_cyc, clr_cyc and ld_ir.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/edge_latch.sv | 30 +++
 rtl/instr_seq.sv | 103 ++++++++++
 tb/tb_instr_seq.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 6502 control slice: default widths,
// the injected BRK opcode, and the interrupt vector select encodings.
package cpu_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CYC_W_DEF  = 3;
  localparam logic [7:0]  BRK_OP_DEF = 8'h00;

  typedef enum logic [1:0] {
    VEC_NONE = 2'b00,
    VEC_IRQ  = 2'b01,
    VEC_NMI  = 2'b10,
    VEC_RST  = 2'b11
  } vec_e;

endpackage

// File: rtl/edge_latch.sv
// Rising-edge detector with a pending flag. Clear beats set, so an edge
// arriving in the same cycle that the flag is serviced is consumed.
module edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  input  logic clr,
  output logic rise,
  output logic pend
);

  logic sig_q;

  assign rise = sig & ~sig_q;

  // Delay stage for edge detection and the pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      sig_q <= sig;
      if (clr)
        pend <= 1'b0;
      else if (rise)
        pend <= 1'b1;
    end
  end

endmodule

// File: rtl/instr_seq.sv
// Instruction sequencer: instruction register, per-instruction cycle
// counter, and reset/NMI/IRQ injection at instruction boundaries.
module instr_seq
  import cpu_pkg::*;
#(
  parameter int unsigned        DATA_W = DATA_W_DEF,
  parameter int unsigned        CYC_W  = CYC_W_DEF,
  parameter logic [DATA_W-1:0]  BRK_OP = DATA_W'(BRK_OP_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ld_ir,
  input  logic              inc_cyc,
  input  logic              clr_cyc,
  input  logic              irq,
  input  logic              nmi,
  input  logic              irq_mask,
  output logic [DATA_W-1:0] ir,
  output logic [CYC_W-1:0]  cycle,
  output logic              int_active,
  output logic [1:0]        vec_sel,
  output logic              nmi_pend,
  output logic              cyc_ovf
);

  logic nmi_rise;
  logic take_nmi;
  logic take_irq;
  logic nmi_clr;
  vec_e vec_q;
  vec_e vec_d;
  logic int_d;

  // A fresh edge counts toward this edge's boundary decision even though
  // the pending flag itself only shows it one clock later.
  assign take_nmi = nmi_pend | nmi_rise;
  assign take_irq = irq & ~irq_mask & ~take_nmi;
  assign nmi_clr  = clr_cyc & take_nmi;
  assign vec_sel  = vec_q;

  edge_latch u_nmi_latch (
    .clk  (clk),
    .rst  (rst),
    .sig  (nmi),
    .clr  (nmi_clr),
    .rise (nmi_rise),
    .pend (nmi_pend)
  );

  // Cycle counter with saturation and a sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle   <= '0;
      cyc_ovf <= 1'b0;
    end else if (clr_cyc) begin
      cycle <= '0;
    end else if (inc_cyc) begin
      if (cycle == '1)
        cyc_ovf <= 1'b1;
      else
        cycle <= cycle + 1'b1;
    end
  end

  // Boundary decision: choose the vector for the next instruction.
  always_comb begin
    int_d = int_active;
    vec_d = vec_q;
    if (clr_cyc) begin
      if (take_nmi) begin
        int_d = 1'b1;
        vec_d = VEC_NMI;
      end else if (take_irq) begin
        int_d = 1'b1;
        vec_d = VEC_IRQ;
      end else begin
        int_d = 1'b0;
        vec_d = VEC_NONE;
      end
    end
  end

  // Injection state register; reset starts the reset sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_active <= 1'b1;
      vec_q      <= VEC_RST;
    end else begin
      int_active <= int_d;
      vec_q      <= vec_d;
    end
  end

  // Instruction register: fetch only in cycle 0, BRK while injecting.
  always_ff @(posedge clk) begin
    if (rst)
      ir <= BRK_OP;
    else if (ld_ir && (cycle == '0))
      ir <= int_active ? BRK_OP : data_in;
  end

endmodule

// File: tb/tb_instr_seq.sv
// Self-checking bench for instr_seq: directed steps followed by random
// traffic, all compared against a behavioural model of the sequencer.
module tb_instr_seq;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, ld_ir, inc_cyc, clr_cyc, irq, nmi, irq_mask;
  logic [DW-1:0] data_in;
  logic [DW-1:0] ir;
  logic [CW-1:0] cycle;
  logic          int_active, nmi_pend, cyc_ovf;
  logic [1:0]    vec_sel;

  int checks = 0;
  int errors = 0;

  // Model state: what the sequencer should hold after each edge.
  int unsigned m_ir, m_cyc, m_vec;
  bit          m_int, m_pend, m_nmiq, m_ovf;

  instr_seq #(.DATA_W(DW), .CYC_W(CW), .BRK_OP(8'h00)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .ld_ir(ld_ir),
    .inc_cyc(inc_cyc), .clr_cyc(clr_cyc), .irq(irq), .nmi(nmi),
    .irq_mask(irq_mask), .ir(ir), .cycle(cycle), .int_active(int_active),
    .vec_sel(vec_sel), .nmi_pend(nmi_pend), .cyc_ovf(cyc_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the rules of one clock edge to the model, using pre-edge state.
  task automatic model_edge();
    bit rise, tnmi, tirq;
    if (rst) begin
      m_ir = 0; m_cyc = 0; m_int = 1; m_vec = 3;
      m_pend = 0; m_nmiq = 0; m_ovf = 0;
      return;
    end
    rise = nmi && !m_nmiq;
    tnmi = m_pend || rise;
    tirq = irq && !irq_mask && !tnmi;
    if (ld_ir && m_cyc == 0)
      m_ir = m_int ? 0 : int'(data_in);
    if (clr_cyc) begin
      m_cyc = 0;
      if (tnmi)      begin m_int = 1; m_vec = 2; m_pend = 0; end
      else if (tirq) begin m_int = 1; m_vec = 1; end
      else           begin m_int = 0; m_vec = 0; end
    end else begin
      if (rise) m_pend = 1;
      if (inc_cyc) begin
        if (m_cyc == CMAX) m_ovf = 1;
        else m_cyc = m_cyc + 1;
      end
    end
    m_nmiq = nmi;
  endtask

  // One clock: update the model at the edge, then compare every output.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("ir",         32'(ir),         32'(m_ir));
    chk("cycle",      32'(cycle),      32'(m_cyc));
    chk("int_active", 32'(int_active), 32'(m_int));
    chk("vec_sel",    32'(vec_sel),    32'(m_vec));
    chk("nmi_pend",   32'(nmi_pend),   32'(m_pend));
    chk("cyc_ovf",    32'(cyc_ovf),    32'(m_ovf));
  endtask

  task automatic idle();
    rst = 0; ld_ir = 0; inc_cyc = 0; clr_cyc = 0;
  endtask

  initial begin
    rst = 0; ld_ir = 0; inc_cyc = 0; clr_cyc = 0;
    irq = 0; nmi = 0; irq_mask = 0; data_in = '0;
    m_ir = 0; m_cyc = 0; m_vec = 0; m_int = 0; m_pend = 0; m_nmiq = 0; m_ovf = 0;
    @(negedge clk);

    // Reset
    rst = 1; data_in = 8'h43;
    tick();
    chk("rst_ir", 32'(ir), 32'h00);
    chk("rst_cycle", 32'(cycle), 0);
    chk("rst_int", 32'(int_active), 1);
    chk("rst_vec", 32'(vec_sel), 3);
    chk("rst_pend", 32'(nmi_pend), 0);

    // Plain fetch and execute
    idle(); clr_cyc = 1; tick();
    idle(); ld_ir = 1; data_in = 8'hA9; tick();
    chk("fetch_ir", 32'(ir), 32'hA9);
    chk("fetch_c0", 32'(cycle), 0);
    idle(); inc_cyc = 1; tick(); chk("exec_c1", 32'(cycle), 1);
    tick(); chk("exec_c2", 32'(cycle), 2);
    idle(); ld_ir = 1; data_in = 8'h55; tick();
    chk("ld_mid_ignored", 32'(ir), 32'hA9);
    idle(); clr_cyc = 1; tick();
    chk("end_c0", 32'(cycle), 0);
    chk("end_int", 32'(int_active), 0);
    chk("end_vec", 32'(vec_sel), 0);

    // Saturation
    idle(); inc_cyc = 1;
    for (int i = 0; i < 8; i++) tick();
    chk("sat_cycle", 32'(cycle), 7);
    chk("sat_ovf", 32'(cyc_ovf), 1);
    idle(); clr_cyc = 1; tick();
    chk("sat_clr_cycle", 32'(cycle), 0);
    chk("sat_ovf_sticky", 32'(cyc_ovf), 1);

    // IRQ unmasked, then masked
    idle(); clr_cyc = 1; irq = 1; irq_mask = 0; tick();
    chk("irq_vec", 32'(vec_sel), 1);
    irq = 0; idle(); ld_ir = 1; data_in = 8'h43; tick();
    chk("irq_brk_ir", 32'(ir), 32'h00);
    idle(); clr_cyc = 1; irq = 1; irq_mask = 1; tick();
    chk("masked_vec", 32'(vec_sel), 0);
    idle(); ld_ir = 1; data_in = 8'h43; tick();
    chk("masked_ir", 32'(ir), 32'h43);

    // NMI edge mid-instruction, held high, beats unmasked IRQ
    irq = 0; irq_mask = 0;
    idle(); inc_cyc = 1; tick(); tick();
    chk("nmi_pre_c2", 32'(cycle), 2);
    idle(); nmi = 1; tick();
    chk("nmi_pend_set", 32'(nmi_pend), 1);
    irq = 1; idle(); clr_cyc = 1; tick();
    chk("nmi_win_vec", 32'(vec_sel), 2);
    chk("nmi_pend_clr", 32'(nmi_pend), 0);
    idle(); inc_cyc = 1; tick();
    idle(); clr_cyc = 1; tick();
    chk("after_nmi_irq_vec", 32'(vec_sel), 1);
    chk("no_second_nmi", 32'(nmi_pend), 0);

    // Reset mid-instruction with NMI pending
    irq = 0; nmi = 0;
    idle(); inc_cyc = 1; tick(); tick(); tick();
    idle(); nmi = 1; tick();
    chk("rst_pre_c3", 32'(cycle), 3);
    chk("rst_pre_pend", 32'(nmi_pend), 1);
    idle(); rst = 1; tick();
    chk("midrst_pend", 32'(nmi_pend), 0);
    chk("midrst_cycle", 32'(cycle), 0);
    chk("midrst_vec", 32'(vec_sel), 3);
    chk("midrst_ir", 32'(ir), 32'h00);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 63) == 0);
      clr_cyc  = ($urandom_range(0, 4) == 0);
      inc_cyc  = ($urandom_range(0, 2) != 0);
      ld_ir    = ($urandom_range(0, 2) == 0);
      irq      = ($urandom_range(0, 3) == 0);
      irq_mask = ($urandom_range(0, 2) == 0);
      nmi      = ($urandom_range(0, 5) == 0) ? ~nmi : nmi;
      data_in  = DW'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
